sync_frame_tx: RTL and testbench

Serial frame transmitter and generator for the team's 1110010 sync-word link. It accepts a parallel payload word over a valid/ready handshake. It then drives one bit per clock on a single serial line, in this order: the 7-bit sync pattern (MSB first), the payload (MSB first), then a run of idle-level guard bits. It sits upstream of any 1110010 sequence detector and is the stimulus source for that detector.

---
 rtl/sync_link_pkg.sv | 25 ++
 rtl/sync_frame_tx_if.sv | 11 +
 rtl/sync_frame_tx_piso.sv | 48 ++++
 rtl/sync_frame_tx.sv | 148 ++++++++++++++
 tb/tb_sync_frame_tx.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sync_link_pkg.sv
// Shared definitions for the 1110010 sync-word link: FSM state encoding,
// the default sync word, and a counter-width helper.
package sync_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Transmitter and detector both take the sync word from here.
  localparam logic [6:0] SYNC_WORD     = 7'b1110010;
  localparam int         SYNC_WORD_LEN = 7;

  // Width needed to hold (max(a,b,c) - 1), never less than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_frame_tx_if.sv
// Payload handshake between a word source and the frame transmitter.
interface sync_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sync_frame_tx_piso.sv
// MSB-first parallel-in serial-out shift register with a down-counter.
// It holds the bits still to be sent after the one currently on the line:
// msb_o is the next bit, last_o flags that the current bit ends the phase.
module piso_shift #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [CNT_W-1:0] load_cnt_i,
  input  logic             shift_i,
  output logic             msb_o,
  output logic             last_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over shift; the counter stops at zero instead of wrapping.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_data_i;
      cnt_d = load_cnt_i;
    end else if (shift_i) begin
      sr_d = sr_q << 1;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o  = sr_q[WIDTH-1];
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, payload (both MSB first), then guard
// bits at idle level. ser_out is registered, so every line value is decided
// one edge ahead from the next state.
module sync_frame_tx
  import sync_link_pkg::*;
#(
  parameter logic [15:0] SYNC_PATTERN = 16'(SYNC_WORD),
  parameter int          SYNC_LEN     = SYNC_WORD_LEN,
  parameter int          DATA_W       = 8,
  parameter int          GAP_LEN      = 2,
  parameter logic        IDLE_LEVEL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_frame_tx_if.slave        tx,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic [1:0]            state
);

  localparam int SR_W  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int CNT_W = cnt_width(SYNC_LEN, DATA_W, GAP_LEN);

  // The first sync bit goes straight to the line; the shifter gets the rest,
  // left-aligned so its MSB is always the next bit to send.
  localparam logic [31:0]     SYNC_MSK   = 32'(SYNC_PATTERN) & ((32'd1 << SYNC_LEN) - 32'd1);
  localparam logic [SR_W-1:0] SYNC_REST  = SR_W'(SYNC_MSK << (SR_W - SYNC_LEN + 1));
  localparam logic            SYNC_FIRST = SYNC_PATTERN[SYNC_LEN-1];

  localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_e            state_q, state_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              take;
  logic              sh_load, sh_shift, sh_msb, sh_last;
  logic [SR_W-1:0]   sh_load_data;
  logic [CNT_W-1:0]  sh_load_cnt;
  logic [SR_W-1:0]   data_rest;

  assign tx.tx_ready = (state_q == ST_IDLE) && !rst;
  assign take        = tx.tx_valid && tx.tx_ready;
  assign data_rest   = SR_W'(data_q) << (SR_W - DATA_W + 1);

  piso_shift #(
    .WIDTH (SR_W),
    .CNT_W (CNT_W)
  ) u_piso (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .load_cnt_i  (sh_load_cnt),
    .shift_i     (sh_shift),
    .msb_o       (sh_msb),
    .last_o      (sh_last)
  );

  // Next state, next line bit and shifter control for each frame phase.
  always_comb begin
    state_d      = state_q;
    ser_d        = IDLE_LEVEL;
    done_d       = 1'b0;
    data_d       = data_q;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_load_cnt  = '0;
    sh_shift     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d      = ST_SYNC;
          ser_d        = SYNC_FIRST;
          data_d       = tx.tx_data;
          sh_load      = 1'b1;
          sh_load_data = SYNC_REST;
          sh_load_cnt  = SYNC_CNT;
        end
      end
      ST_SYNC: begin
        if (sh_last) begin
          state_d      = ST_DATA;
          ser_d        = data_q[DATA_W-1];
          sh_load      = 1'b1;
          sh_load_data = data_rest;
          sh_load_cnt  = DATA_CNT;
        end else begin
          ser_d    = sh_msb;
          sh_shift = 1'b1;
        end
      end
      ST_DATA: begin
        if (sh_last) begin
          if (GAP_LEN > 0) begin
            state_d     = ST_GAP;
            sh_load     = 1'b1;
            sh_load_cnt = GAP_CNT;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          ser_d    = sh_msb;
          sh_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (sh_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          sh_shift = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Registered FSM state, line and status; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ser_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign ser_out    = ser_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Scoreboard bench for sync_frame_tx: the stimulus process pushes the
// expected per-cycle line/status values into a queue, the monitor pops one
// entry per clock and compares. A second instance covers DATA_W=1, GAP_LEN=0.
module tb_sync_frame_tx;
  import sync_link_pkg::*;

  typedef struct packed {
    logic       ser;
    logic       busy;
    logic       done;
    logic [1:0] st;
    logic       rdy;
    logic       sync_end;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ser_out, busy, frame_done;
  logic [1:0] state;
  logic       rst1;
  logic       ser1, busy1, done1;
  logic [1:0] state1;

  sync_frame_tx_if #(.DATA_W(8)) txif ();
  sync_frame_tx_if #(.DATA_W(1)) txif1 ();

  sync_frame_tx #(.DATA_W(8), .GAP_LEN(2)) dut (
    .clk(clk), .rst(rst), .tx(txif), .ser_out(ser_out),
    .busy(busy), .frame_done(frame_done), .state(state)
  );

  sync_frame_tx #(.DATA_W(1), .GAP_LEN(0)) dut1 (
    .clk(clk), .rst(rst1), .tx(txif1), .ser_out(ser1),
    .busy(busy1), .frame_done(done1), .state(state1)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         det_cnt = 0;
  int         model_free = 0;
  bit         mon_en = 1'b0;
  logic [6:0] pat = 7'b1110010;
  logic [6:0] hist = '0;
  exp_t       exp_q[$];

  function automatic exp_t mk(logic s, logic b, logic d, logic [1:0] st, logic r, logic se);
    exp_t e;
    e.ser = s; e.busy = b; e.done = d; e.st = st; e.rdy = r; e.sync_end = se;
    return e;
  endfunction

  // Whole frame as the line should show it, one entry per cycle, then the
  // first idle cycle carrying frame_done.
  task automatic push_frame(input logic [7:0] d);
    for (int i = 6; i >= 0; i--) exp_q.push_back(mk(pat[i], 1'b1, 1'b0, 2'd1, 1'b0, i == 0));
    for (int i = 7; i >= 0; i--) exp_q.push_back(mk(d[i], 1'b1, 1'b0, 2'd2, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++)  exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0));
  endtask

  // One clock of stimulus plus the reference model's view of that edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    txif.tx_valid = v;
    txif.tx_data = d;
    mon_en = 1'b1;
    if (r) begin
      exp_q.delete();
      model_free = 0;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0));
    end else if (model_free > 0) begin
      model_free--;
    end else if (v) begin
      push_frame(d);
      model_free = 17;
    end else begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0));
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: compare every cycle against the scoreboard, and run a
  // behavioural 1110010 detector on the line.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        hist = {hist[5:0], ser_out};
        if (hist == pat) det_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL underflow cyc%0d: no expected entry", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({ser_out, busy, frame_done, state, txif.tx_ready} !== {e.ser, e.busy, e.done, e.st, e.rdy}) begin
            fails++;
            $display("FAIL cycle cyc%0d: ser/busy/done/state/ready got %b %b %b %0d %b, expected %b %b %b %0d %b",
                     cyc, ser_out, busy, frame_done, state, txif.tx_ready, e.ser, e.busy, e.done, e.st, e.rdy);
          end
          if (e.sync_end) begin
            tests++;
            if (hist !== pat) begin
              fails++;
              $display("FAIL sync_align cyc%0d: last 7 bits %b, expected %b", cyc, hist, pat);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [8:0] g1;
    int k;
    rst = 1'b1; txif.tx_valid = 1'b0; txif.tx_data = '0;
    rst1 = 1'b1; txif1.tx_valid = 1'b0; txif1.tx_data = '0;

    // Reset then quiet idle
    repeat (2) step(1'b1, 1'b0, 8'h00);
    repeat (5) step(1'b0, 1'b0, 8'h00);

    // Single frame
    step(1'b0, 1'b1, 8'hA5);
    repeat (20) step(1'b0, 1'b0, 8'($urandom));

    // Back-to-back with valid held; data churns mid-frame
    step(1'b0, 1'b1, 8'hFF);
    repeat (17) step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 8'h00);
    repeat (17) step(1'b0, 1'b1, 8'($urandom));
    repeat (20) step(1'b0, 1'b0, 8'h00);

    // Reset on the 4th data bit, valid high through the reset edge
    step(1'b0, 1'b1, 8'h3C);
    repeat (10) step(1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 8'h81);
    step(1'b0, 1'b1, 8'h81);
    step(1'b0, 1'b0, 8'h00);
    repeat (20) step(1'b0, 1'b0, 8'h00);

    // Loopback: all-zero payloads give exactly one sync hit per frame
    d0 = det_cnt;
    step(1'b0, 1'b1, 8'h00);
    repeat (19) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    repeat (19) step(1'b0, 1'b0, 8'h00);
    chk("loopback_matches", det_cnt - d0, 2);

    // Randomised traffic with occasional resets
    repeat (300) step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
    repeat (20) step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 0);

    // Narrow build: DATA_W=1, GAP_LEN=0, payload 1, valid held high
    g1 = 9'b111001010;
    txif1.tx_valid = 1'b1;
    txif1.tx_data = 1'b1;
    @(posedge clk); #1;
    chk("n_rst_ser", ser1, 0);
    chk("n_rst_state", state1, 0);
    chk("n_rst_ready", txif1.tx_ready, 0);
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      k = i % 9;
      chk($sformatf("n_ser_%0d", i), ser1, g1[8 - k]);
      chk($sformatf("n_done_%0d", i), done1, (k == 8) ? 1 : 0);
      chk($sformatf("n_state_%0d", i), state1, (k < 7) ? 1 : ((k == 7) ? 2 : 0));
    end
    txif1.tx_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
